regfile_wb_arbiter: RTL
=======================

Name: regfile_wb_arbiter

Overview:
- Shares the single write port of the 32x32 register file between two writeback requesters: req0 is the ALU result and req1 is the load/memory result.
- Round-robin arbitration grants one write per cycle.
- Writes are driven to the register file one cycle after grant.
- Maintains a pending-write scoreboard so decode can stall reads of registers whose producer has not yet written back.

Parameters:
DATA_W, 32, width of write data
ADDR_W, 5, register index width
NREG, 32, number of registers (2**ADDR_W)

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
req0_valid  input  1  requester 0 (ALU) has a write
req0_reg  input  ADDR_W  destination register, requester 0
req0_data  input  DATA_W  write data, requester 0
req0_ready  output  1  grant to requester 0 this cycle (combinational)
req1_valid  input  1  requester 1 (load) has a write
req1_reg  input  ADDR_W  destination register, requester 1
req1_data  input  DATA_W  write data, requester 1
req1_ready  output  1  grant to requester 1 this cycle (combinational)
issue_valid  input  1  decode issued an instruction with a destination
issue_reg  input  ADDR_W  destination being issued
readReg1  input  ADDR_W  decode source register 1
readReg2  input  ADDR_W  decode source register 2
busy1  output  1  readReg1 has a pending write (combinational)
busy2  output  1  readReg2 has a pending write (combinational)
writeReg  output  ADDR_W  register-file write index (registered)
writeData  output  DATA_W  register-file write data (registered)
RegWrite  output  1  register-file write enable (registered)

Behaviour:
- Clock and reset: single clock clk. reset is synchronous and active-high, sampled only at the rising edge.
- Reset values: RegWrite=0, writeReg=0, writeData=0, prio=0 (requester 0 favoured), pending[NREG-1:0]=0.
- Reset mid-operation: any granted-but-uncommitted write is dropped. RegWrite=0 on the cycle after reset is sampled.
- While reset is high, req0_ready=req1_ready=0 and busy1=busy2=0.
- Arbitration (combinational, one cycle), outside reset:
  - Only one requester valid: that requester gets ready=1.
  - Both valid: the prio side gets ready=1; the other gets ready=0.
  - Neither valid: both ready=0.
  - A handshake is valid&&ready. Requesters hold reg/data stable until ready.
- Priority update: after any grant to requester N, prio <= the other requester. With no grant, prio is unchanged.
- Write latency: exactly 1 cycle. A grant in cycle t gives RegWrite=1 in cycle t+1, with writeReg/writeData equal to the granted reg/data. With no grant, RegWrite=0 the next cycle; writeReg/writeData hold their last values.
- Throughput: one write per cycle sustained; back-to-back grants are allowed.
- Scoreboard, per-cycle update:
  - Set pending[issue_reg] when issue_valid.
  - Clear pending[writeReg] when RegWrite=1 (commit cycle).
  - Same register set and cleared in the same cycle: set wins (newer producer outstanding).
  - Set of an already-set bit: stays set. No counting; at most one outstanding producer per register is the decode contract.
  - Clear of an unset bit: no effect.
- Busy lookup: busy1=pending[readReg1], busy2=pending[readReg2], from registered state only. No forwarding of same-cycle issue or commit.
  - A register committing in cycle t reads busy=0 from cycle t+1. The register file's write is visible at that edge.
- Register 0: no special handling. It is writable and scoreboarded like every other index.
- A write request to a non-pending register is legal and is performed normally.

Decomposition:
- Shared package holds DATA_W, ADDR_W and NREG, shared with the register file.
- Natural sub-module: wb_rr_arbiter (2-way round-robin grant plus prio flop).
- Scoreboard and output registers stay in the top.

Test Plan:
- Reset: assert reset 2 cycles while req0_valid=1 -> ready0=0, RegWrite=0, busy1=busy2=0. After release, the first req0 (reg 3, data 69) is granted; next cycle RegWrite=1, writeReg=3, writeData=69.
- Contention: req0 (r5, 35) and req1 (r6, 70) valid together for 2 cycles after reset -> cycle 0 grants req0, cycle 1 grants req1. Writes appear at cycles 1 and 2 in that order.
- Fairness: both valid continuously for 6 cycles with distinct regs -> grants alternate 0,1,0,1,0,1. RegWrite stays high cycles 1-6.
- Scoreboard: issue r7; next cycle readReg1=7 -> busy1=1. req1 writes r7 data 99 -> busy1 stays 1 through the commit cycle, then drops to 0 the cycle after.
- Simultaneous set/clear: issue r9 on the same cycle r9 commits -> pending[9]=1 afterwards, busy2=1 for readReg2=9.
- Reset mid-flight: grant req0 (r4) and assert reset the same cycle -> next cycle RegWrite=0 and pending is all zero.

Source files
------------

// File: rtl/regfile_wb_arbiter_pkg.sv
// Register-file geometry shared by the writeback arbiter and the register file,
// plus the round-robin priority encoding.
package regfile_wb_arbiter_pkg;

    localparam int RF_DATA_W = 32;
    localparam int RF_ADDR_W = 5;
    localparam int RF_NREG   = 1 << RF_ADDR_W;

    typedef enum logic {
        PRIO_ALU  = 1'b0,
        PRIO_LOAD = 1'b1
    } prio_e;

    function automatic prio_e other_side(input prio_e side);
        return (side == PRIO_ALU) ? PRIO_LOAD : PRIO_ALU;
    endfunction

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin grant with priority flop; grant is combinational (0 cycles).
// The losing requester sees no grant and must hold its request.
module wb_rr_arbiter
    import regfile_wb_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req_vld_i,
    output logic [1:0] gnt_o
);

    prio_e prio_q;
    prio_e prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!reset) begin
            if (req_vld_i == 2'b11) begin
                gnt_o = (prio_q == PRIO_ALU) ? 2'b01 : 2'b10;
            end else begin
                gnt_o = req_vld_i;
            end
        end
    end

    // The side just served yields priority to the other one.
    always_comb begin
        prio_d = prio_q;
        if (|gnt_o) begin
            prio_d = other_side(gnt_o[1] ? PRIO_LOAD : PRIO_ALU);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= PRIO_ALU;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback; write lands 1 cycle after grant.
// Losing requester is held off via ready=0; pending scoreboard lets decode stall on busy sources.
module regfile_wb_arbiter
    import regfile_wb_arbiter_pkg::*;
#(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREG   = RF_NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_reg,
    input  logic [DATA_W-1:0] req0_data,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_reg,
    input  logic [DATA_W-1:0] req1_data,
    output logic              req1_ready,
    input  logic              issue_valid,
    input  logic [ADDR_W-1:0] issue_reg,
    input  logic [ADDR_W-1:0] readReg1,
    input  logic [ADDR_W-1:0] readReg2,
    output logic              busy1,
    output logic              busy2,
    output logic [ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0] writeData,
    output logic              RegWrite
);

    logic [1:0]        gnt;
    logic              reg_wr_q,  reg_wr_d;
    logic [ADDR_W-1:0] wr_reg_q,  wr_reg_d;
    logic [DATA_W-1:0] wr_dat_q,  wr_dat_d;
    logic [NREG-1:0]   pending_q, pending_d;

    wb_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_vld_i ({req1_valid, req0_valid}),
        .gnt_o     (gnt)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];

    always_comb begin
        reg_wr_d = |gnt;
        wr_reg_d = wr_reg_q;
        wr_dat_d = wr_dat_q;
        if (gnt[0]) begin
            wr_reg_d = req0_reg;
            wr_dat_d = req0_data;
        end else if (gnt[1]) begin
            wr_reg_d = req1_reg;
            wr_dat_d = req1_data;
        end
    end

    // Set after clear so a newly issued producer outlives a same-cycle commit.
    always_comb begin
        pending_d = pending_q;
        if (reg_wr_q) begin
            pending_d[wr_reg_q] = 1'b0;
        end
        if (issue_valid) begin
            pending_d[issue_reg] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reg_wr_q  <= 1'b0;
            wr_reg_q  <= '0;
            wr_dat_q  <= '0;
            pending_q <= '0;
        end else begin
            reg_wr_q  <= reg_wr_d;
            wr_reg_q  <= wr_reg_d;
            wr_dat_q  <= wr_dat_d;
            pending_q <= pending_d;
        end
    end

    assign busy1     = reset ? 1'b0 : pending_q[readReg1];
    assign busy2     = reset ? 1'b0 : pending_q[readReg2];
    assign RegWrite  = reg_wr_q;
    assign writeReg  = wr_reg_q;
    assign writeData = wr_dat_q;

endmodule
